// File: rtl/ibuf_queue_pkg.sv
// Shared types and build-time configuration helpers for the instruction buffer.
package ibuf_queue_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN_DEF = 32;

  // One buffered instruction slot at the default widths.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pred_npc;
    logic                slot_valid;
  } ibuf_entry_t;

  typedef struct packed {
    logic        bypass_en;
    int unsigned instr_per_fetch;
    int unsigned decode_width;
    int unsigned depth;
  } cfg_t;

  // Highest count at which a whole fetch group still fits.
  function automatic int ready_limit(cfg_t c);
    return int'(c.depth) - int'(c.instr_per_fetch);
  endfunction

  function automatic logic bypass_on(cfg_t c);
    return c.bypass_en;
  endfunction

endpackage

// File: rtl/ibuf_queue_compact.sv
// Mask compaction: popcount plus the ascending list of valid slot indices.
module ibuf_compact #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2,
  parameter int unsigned CW = 3
) (
  input  logic [N-1:0]    i_mask,
  output logic [CW-1:0]   o_cnt,
  output logic [N*IW-1:0] o_idx
);

  always_comb begin
    int pos;
    pos   = 0;
    o_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (i_mask[i]) begin
        o_idx[pos*IW +: IW] = IW'(i);
        pos++;
      end
    end
    o_cnt = CW'(pos);
  end

endmodule

// File: rtl/ibuf_queue.sv
// Instruction buffer between fetch and decode: compacting circular queue with
// flush, independent fetch/decode widths and optional empty-queue bypass.
module ibuf_queue
  import ibuf_queue_pkg::*;
#(
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned DECODE_WIDTH    = 4,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned ILEN            = 32,
  parameter int unsigned BYPASS_EN       = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_flush,
  input  logic                              i_fq_valid,
  output logic                              o_fq_ready,
  input  logic [INSTR_PER_FETCH-1:0]        i_fq_slot_valid,
  input  logic [INSTR_PER_FETCH*XLEN-1:0]   i_fq_pc,
  input  logic [INSTR_PER_FETCH*ILEN-1:0]   i_fq_instr,
  input  logic [INSTR_PER_FETCH*XLEN-1:0]   i_fq_pred_npc,
  output logic [DECODE_WIDTH-1:0]           o_dec_valid,
  output logic [DECODE_WIDTH*XLEN-1:0]      o_dec_pc,
  output logic [DECODE_WIDTH*ILEN-1:0]      o_dec_instr,
  output logic [DECODE_WIDTH*XLEN-1:0]      o_dec_pred_npc,
  input  logic                              i_dec_ready,
  output logic [$clog2(DEPTH):0]            o_count
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned IW    = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int unsigned NW    = $clog2(INSTR_PER_FETCH + 1);
  localparam int          IPF_I = int'(INSTR_PER_FETCH);
  localparam int          DW_I  = int'(DECODE_WIDTH);

  localparam cfg_t CFG = '{
    bypass_en:       1'(BYPASS_EN != 0),
    instr_per_fetch: INSTR_PER_FETCH,
    decode_width:    DECODE_WIDTH,
    depth:           DEPTH
  };
  localparam int READY_LIMIT = ready_limit(CFG);
  localparam bit BYP         = bypass_on(CFG);

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fq_ready_q, fq_ready_d;
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] pc_d    [DEPTH];
  logic [ILEN-1:0] instr_q [DEPTH];
  logic [ILEN-1:0] instr_d [DEPTH];
  logic [XLEN-1:0] npc_q   [DEPTH];
  logic [XLEN-1:0] npc_d   [DEPTH];

  logic [NW-1:0]                 n_in_c;
  logic [INSTR_PER_FETCH*IW-1:0] idx_c;

  ibuf_compact #(
    .N  (INSTR_PER_FETCH),
    .IW (IW),
    .CW (NW)
  ) u_compact (
    .i_mask (i_fq_slot_valid),
    .o_cnt  (n_in_c),
    .o_idx  (idx_c)
  );

  assign o_count    = count_q;
  assign o_fq_ready = fq_ready_q;

  // Output selection, dequeue, compacted enqueue and pointer/count update.
  always_comb begin
    int            n_in, n_show, n_deq, n_skip, n_wr, src;
    logic          byp, enq;
    logic [IW-1:0] slot;

    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    npc_d          = npc_q;
    o_dec_valid    = '0;
    o_dec_pc       = '0;
    o_dec_instr    = '0;
    o_dec_pred_npc = '0;
    slot           = '0;
    src            = 0;

    n_in = int'(n_in_c);
    byp  = BYP && (count_q == '0) && i_fq_valid && !i_flush;
    enq  = i_fq_valid && fq_ready_q && !i_flush;

    n_show = byp ? n_in : int'(count_q);
    if (n_show > DW_I) n_show = DW_I;
    if (i_flush) n_show = 0;

    for (int k = 0; k < DW_I; k++) begin
      if (k < n_show) begin
        o_dec_valid[k] = 1'b1;
        if (byp) begin
          slot = idx_c[k*IW +: IW];
          src  = int'(slot);
          o_dec_pc[k*XLEN +: XLEN]       = i_fq_pc[src*XLEN +: XLEN];
          o_dec_instr[k*ILEN +: ILEN]    = i_fq_instr[src*ILEN +: ILEN];
          o_dec_pred_npc[k*XLEN +: XLEN] = i_fq_pred_npc[src*XLEN +: XLEN];
        end else begin
          o_dec_pc[k*XLEN +: XLEN]       = pc_q[head_q + PW'(k)];
          o_dec_instr[k*ILEN +: ILEN]    = instr_q[head_q + PW'(k)];
          o_dec_pred_npc[k*XLEN +: XLEN] = npc_q[head_q + PW'(k)];
        end
      end
    end

    // Bypassed entries consumed by decode are skipped rather than dequeued.
    n_deq  = (i_dec_ready && !byp) ? n_show : 0;
    n_skip = (i_dec_ready && byp) ? n_show : 0;
    n_wr   = enq ? (n_in - n_skip) : 0;

    for (int k = 0; k < IPF_I; k++) begin
      if (k < n_wr) begin
        slot = idx_c[(k+n_skip)*IW +: IW];
        src  = int'(slot);
        pc_d[tail_q + PW'(k)]    = i_fq_pc[src*XLEN +: XLEN];
        instr_d[tail_q + PW'(k)] = i_fq_instr[src*ILEN +: ILEN];
        npc_d[tail_q + PW'(k)]   = i_fq_pred_npc[src*XLEN +: XLEN];
      end
    end

    tail_d  = tail_q + PW'(n_wr);
    head_d  = head_q + PW'(n_deq);
    count_d = count_q + CW'(n_wr) - CW'(n_deq);

    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    fq_ready_d = (int'(count_d) <= READY_LIMIT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fq_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fq_ready_q <= fq_ready_d;
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge i_clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
    npc_q   <= npc_d;
  end

endmodule

// File: tb/tb_ibuf_queue.sv
// Directed and randomized checks of ibuf_queue against a queue-based model.
module tb_ibuf_queue;

  localparam int IPF   = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst, flush, fq_valid, dec_ready;
  logic [3:0]   mask;
  logic [127:0] fq_pc, fq_in, fq_np;
  logic         rdy, rdy_b;
  logic [3:0]   dv, dv_b;
  logic [127:0] dpc, din, dnp, dpc_b, din_b, dnp_b;
  logic [4:0]   cnt, cnt_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc[$], m_in[$], m_np[$];
  logic [31:0] enq_seq[$], deq_seq[$];
  bit          track = 1'b0;

  always #5 clk = ~clk;

  ibuf_queue #(.INSTR_PER_FETCH(4), .DECODE_WIDTH(4), .DEPTH(16), .XLEN(32), .ILEN(32), .BYPASS_EN(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_fq_valid(fq_valid), .o_fq_ready(rdy),
    .i_fq_slot_valid(mask), .i_fq_pc(fq_pc), .i_fq_instr(fq_in), .i_fq_pred_npc(fq_np),
    .o_dec_valid(dv), .o_dec_pc(dpc), .o_dec_instr(din), .o_dec_pred_npc(dnp),
    .i_dec_ready(dec_ready), .o_count(cnt)
  );

  ibuf_queue #(.INSTR_PER_FETCH(4), .DECODE_WIDTH(4), .DEPTH(16), .XLEN(32), .ILEN(32), .BYPASS_EN(1)) dut_byp (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_fq_valid(fq_valid), .o_fq_ready(rdy_b),
    .i_fq_slot_valid(mask), .i_fq_pc(fq_pc), .i_fq_instr(fq_in), .i_fq_pred_npc(fq_np),
    .o_dec_valid(dv_b), .o_dec_pc(dpc_b), .o_dec_instr(din_b), .o_dec_pred_npc(dnp_b),
    .i_dec_ready(dec_ready), .o_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pop4(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    return n;
  endfunction

  task automatic set_group(input logic [3:0] m, input logic [31:0] base);
    mask = m;
    for (int i = 0; i < IPF; i++) begin
      fq_pc[i*32 +: 32] = base + 32'(4*i);
      fq_in[i*32 +: 32] = $urandom;
      fq_np[i*32 +: 32] = $urandom;
    end
  endtask

  // Check the DUT against the model for the current inputs, then advance one cycle.
  task automatic step();
    int          n, nshow;
    logic [3:0]  ev;
    logic        exp_rdy, acc;
    #1;
    n       = m_pc.size();
    nshow   = flush ? 0 : ((n < DW) ? n : DW);
    ev      = '0;
    for (int k = 0; k < DW; k++) if (k < nshow) ev[k] = 1'b1;
    exp_rdy = (DEPTH - n) >= IPF;
    chk("count", 128'(cnt), 128'(n));
    chk("fq_ready", 128'(rdy), 128'(exp_rdy));
    chk("dec_valid", 128'(dv), 128'(ev));
    for (int k = 0; k < nshow; k++) begin
      chk($sformatf("pc%0d", k), 128'(dpc[k*32 +: 32]), 128'(m_pc[k]));
      chk($sformatf("instr%0d", k), 128'(din[k*32 +: 32]), 128'(m_in[k]));
      chk($sformatf("npc%0d", k), 128'(dnp[k*32 +: 32]), 128'(m_np[k]));
    end
    if (track && dec_ready)
      for (int k = 0; k < DW; k++) if (dv[k]) deq_seq.push_back(dpc[k*32 +: 32]);
    acc = fq_valid && exp_rdy && !flush;
    if (flush) begin
      m_pc.delete(); m_in.delete(); m_np.delete();
    end else begin
      if (dec_ready)
        for (int k = 0; k < nshow; k++) begin
          void'(m_pc.pop_front()); void'(m_in.pop_front()); void'(m_np.pop_front());
        end
      if (acc)
        for (int i = 0; i < IPF; i++)
          if (mask[i]) begin
            m_pc.push_back(fq_pc[i*32 +: 32]);
            m_in.push_back(fq_in[i*32 +: 32]);
            m_np.push_back(fq_np[i*32 +: 32]);
            if (track) enq_seq.push_back(fq_pc[i*32 +: 32]);
          end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc_ctr;
    int          pushed;
    bit          pending, accepted;

    rst = 1'b1; flush = 1'b0; fq_valid = 1'b0; dec_ready = 1'b0;
    mask = '0; fq_pc = '0; fq_in = '0; fq_np = '0;
    pc_ctr = 32'h0001_0000;

    // Reset values
    #3;
    chk("rst_count", 128'(cnt), 128'(0));
    chk("rst_valid", 128'(dv), 128'(0));
    chk("rst_ready", 128'(rdy), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    step();

    // Sparse mask compaction
    set_group(4'b1011, 32'h1000);
    fq_valid = 1'b1;
    step();
    fq_valid = 1'b0;
    chk("cmp_count", 128'(cnt), 128'(3));
    chk("cmp_valid", 128'(dv), 128'(4'b0111));
    chk("cmp_pc0", 128'(dpc[31:0]), 128'(32'h1000));
    chk("cmp_pc1", 128'(dpc[63:32]), 128'(32'h1004));
    chk("cmp_pc2", 128'(dpc[95:64]), 128'(32'h100C));
    step();
    flush = 1'b1; step(); flush = 1'b0;

    // Fill to full, then one dequeue restores ready
    fq_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      set_group(4'hF, 32'h4000 + 32'(16*g));
      step();
      if (g == 2) begin
        chk("fill3_count", 128'(cnt), 128'(12));
        chk("fill3_ready", 128'(rdy), 128'(1));
      end
    end
    chk("full_count", 128'(cnt), 128'(16));
    chk("full_ready", 128'(rdy), 128'(0));
    set_group(4'hF, 32'h5000);
    step();
    fq_valid = 1'b0; dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk("deq_count", 128'(cnt), 128'(12));
    chk("deq_ready", 128'(rdy), 128'(1));

    // Asynchronous reset mid-operation
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 128'(cnt), 128'(0));
    chk("arst_valid", 128'(dv), 128'(0));
    chk("arst_ready", 128'(rdy), 128'(1));
    m_pc.delete(); m_in.delete(); m_np.delete();
    @(negedge clk);
    rst = 1'b0;
    step();

    // Random streaming across pointer wrap
    track = 1'b1; pushed = 0; pending = 1'b0;
    for (int cyc = 0; cyc < 400 && (pushed < 40 || pending || m_pc.size() != 0); cyc++) begin
      if (!pending && pushed < 40) begin
        set_group(4'($urandom_range(0, 15)), pc_ctr);
        pc_ctr  += 32'h10;
        pending  = 1'b1;
        fq_valid = 1'b1;
      end
      dec_ready = 1'($urandom_range(0, 1));
      accepted  = pending && ((DEPTH - m_pc.size()) >= IPF);
      step();
      if (accepted) begin
        pushed  += pop4(mask);
        pending  = 1'b0;
        fq_valid = 1'b0;
      end
    end
    track = 1'b0; dec_ready = 1'b0; fq_valid = 1'b0;
    chk("stream_len", 128'(deq_seq.size()), 128'(enq_seq.size()));
    chk("stream_drained", 128'(cnt), 128'(0));
    for (int i = 0; i < enq_seq.size() && i < deq_seq.size(); i++)
      chk($sformatf("stream%0d", i), 128'(deq_seq[i]), 128'(enq_seq[i]));

    // Flush wins over simultaneous enqueue and dequeue
    fq_valid = 1'b1;
    set_group(4'hF, 32'h6000); step();
    set_group(4'hF, 32'h6010); step();
    set_group(4'b0001, 32'h6020); step();
    fq_valid = 1'b0;
    chk("pre_flush_count", 128'(cnt), 128'(9));
    flush = 1'b1; fq_valid = 1'b1; dec_ready = 1'b1;
    set_group(4'hF, 32'h6030);
    step();
    flush = 1'b0; fq_valid = 1'b0; dec_ready = 1'b0;
    chk("flush_count", 128'(cnt), 128'(0));
    chk("flush_valid", 128'(dv), 128'(0));
    step();

    // Bypass on empty queue, decode ready
    chk("byp_idle_count", 128'(cnt_b), 128'(0));
    set_group(4'hF, 32'h2000);
    fq_valid = 1'b1; dec_ready = 1'b1;
    #1;
    chk("byp_valid", 128'(dv_b), 128'(4'b1111));
    for (int k = 0; k < 4; k++)
      chk($sformatf("byp_pc%0d", k), 128'(dpc_b[k*32 +: 32]), 128'(32'h2000 + 32'(4*k)));
    chk("byp_instr3", 128'(din_b[127:96]), 128'(fq_in[127:96]));
    step();
    fq_valid = 1'b0; dec_ready = 1'b0;
    #1;
    chk("byp_count", 128'(cnt_b), 128'(0));
    chk("byp_after_valid", 128'(dv_b), 128'(0));
    chk("nobyp_count", 128'(cnt), 128'(4));
    @(negedge clk);
    flush = 1'b1; step(); flush = 1'b0;

    // Bypass on empty queue, decode stalled: everything is still written
    set_group(4'b0101, 32'h3000);
    fq_valid = 1'b1;
    #1;
    chk("bypst_valid", 128'(dv_b), 128'(4'b0011));
    chk("bypst_pc0", 128'(dpc_b[31:0]), 128'(32'h3000));
    chk("bypst_pc1", 128'(dpc_b[63:32]), 128'(32'h3008));
    step();
    fq_valid = 1'b0;
    #1;
    chk("bypst_count", 128'(cnt_b), 128'(2));
    chk("bypst_hold_valid", 128'(dv_b), 128'(4'b0011));
    chk("bypst_hold_pc1", 128'(dpc_b[63:32]), 128'(32'h3008));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
